// File: rtl/alu_mult_seq.sv
// Shift-add unsigned multiplier that sequences the shared ALU with ADD ops.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module alu_mult_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      product,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [31:0]      acc;
  logic [31:0]      mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc_nx;
  logic             last;

  assign acc_nx = mplier[0] ? alu_out : acc;

`ifdef MULT_EARLY_EXIT_EN
  assign last = (cnt == LAST) || ((mplier >> 1) == '0);
`else
  assign last = (cnt == LAST);
`endif

  assign busy   = (state == S_RUN) || (state == S_DONE);
  assign done   = (state == S_DONE);
  assign alu_a  = (state == S_RUN) ? acc : '0;
  assign alu_b  = (state == S_RUN) ? mcand : '0;
  assign alu_op = (state == S_RUN) ? OP_ADD : OP_AND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= 32'(a_in);
            mplier <= b_in;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            product <= acc_nx;
            state   <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Randomized self-checking bench for alu_mult_seq with a behavioural ALU.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_alu_mult_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [31:0]      product;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_op;
  logic [31:0]      alu_out;

  int checks = 0;
  int errors = 0;

  alu_mult_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared ALU stand-in
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd0: alu_out = alu_a & alu_b;
      3'd1: alu_out = alu_a | alu_b;
      3'd2: alu_out = alu_a + alu_b;
      default: alu_out = alu_a - alu_b;
    endcase
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int run_len(logic [WIDTH-1:0] b);
    int r;
    r = WIDTH;
`ifdef MULT_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) r = i + 1;
`endif
    return r;
  endfunction

  // called at a negedge with the DUT idle
  task automatic do_mult(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    int n;
    logic [31:0] exp;
    exp = 32'(a) * 32'(b);
    start = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    check("run_op", 32'(alu_op), 32'd2);
    check("run_alu_a", alu_a, 32'd0);
    check("run_alu_b", alu_b, 32'(a));
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(run_len(b)));
    check("product", product, exp);
    check("busy_done", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int t_prev;
    int w;
    logic [31:0] held;

    reset = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_mult(16'd25, 16'd23);
    do_mult(16'hFFFF, 16'hFFFF);
    do_mult(16'd0, 16'd1234);
    do_mult(16'd1234, 16'd0);
    do_mult(16'd1, 16'h8000);
    for (int i = 0; i < 20; i++)
      do_mult(WIDTH'($urandom), WIDTH'($urandom));

    // start held high; operands scrambled while busy
    start = 1'b1;
    a_in = 16'd3;
    b_in = 16'd5;
    cyc = 0;
    ndone = 0;
    t_prev = 0;
    while (ndone < 3 && cyc < 120) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
        check("held_product", product, 32'd15);
        if (ndone > 0)
          check("held_period", 32'(cyc - t_prev), 32'(run_len(16'd5) + 2));
        t_prev = cyc;
        ndone++;
        a_in = 16'd3;
        b_in = 16'd5;
      end else if (busy) begin
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
      end
    end
    check("held_count", 32'(ndone), 32'd3);
    start = 1'b0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("held_idle", 32'(busy), 32'd0);

    // asynchronous abort during RUN
    start = 1'b1;
    a_in = 16'd100;
    b_in = 16'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_op", 32'(alu_op), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (done || busy) w++;
    end
    check("abort_no_done", 32'(w), 32'd0);
    do_mult(16'd100, 16'd200);

    // idle hold
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_alu_a", alu_a, 32'd0);
      check("idle_alu_b", alu_b, 32'd0);
      check("idle_op", 32'(alu_op), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_product", product, 32'd20000);
    end
    check("idle_held", product, held);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
